// File: rtl/lieat_exu_com_csrctrl.sv
// Commit-stage CSR access sequencer: one CSR op, TRAP or MRET per handshake, read-then-write on a single-port CSR file.
// Optional feature: define LIEAT_CSR_MSTATUS_STACK_EN to let TRAP/MRET stack/unstack mstatus.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef CSR_IDX
`define CSR_IDX 12
`endif

module lieat_exu_com_csrctrl (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [`CSR_IDX-1:0] req_idx,
    input  logic [`XLEN-1:0]    req_src,
    input  logic                req_src_zero,
    input  logic [`XLEN-1:0]    req_pc,
    input  logic [`XLEN-1:0]    req_cause,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [`XLEN-1:0]    resp_rdata,
    output logic                csr_ena,
    output logic                csr_read,
    output logic                csr_write,
    output logic [`CSR_IDX-1:0] csr_idx,
    output logic [`CSR_IDX-1:0] csr_idx2,
    output logic [`XLEN-1:0]    csr_wdata,
    output logic [`XLEN-1:0]    csr_wdata2,
    input  logic [`XLEN-1:0]    csr_rdata
);

`ifdef LIEAT_CSR_MSTATUS_STACK_EN
    localparam logic STACK_EN = 1'b1;
`else
    localparam logic STACK_EN = 1'b0;
`endif

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_TRAP  = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [`CSR_IDX-1:0] ADDR_MSTATUS = 12'h300;
    localparam logic [`CSR_IDX-1:0] ADDR_MEPC    = 12'h341;
    localparam logic [`CSR_IDX-1:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TRAP = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    typedef struct packed {
        logic                req_ready;
        logic                resp_valid;
        logic [`XLEN-1:0]    resp_rdata;
        logic                csr_ena;
        logic                csr_read;
        logic                csr_write;
        logic [`CSR_IDX-1:0] csr_idx;
        logic [`CSR_IDX-1:0] csr_idx2;
        logic [`XLEN-1:0]    csr_wdata;
        logic [`XLEN-1:0]    csr_wdata2;
    } drive_t;

    // Modify step of the read-modify-write; TRAP/MRET rewrite the mstatus interrupt stack fields.
    function automatic logic [`XLEN-1:0] wr_data_f(input logic [2:0] op,
                                                   input logic [`XLEN-1:0] old,
                                                   input logic [`XLEN-1:0] src);
        logic [`XLEN-1:0] w;
        w = old;
        case (op)
            OP_CSRRW: w = src;
            OP_CSRRS: w = old | src;
            OP_CSRRC: w = old & ~src;
            OP_TRAP: begin
                w[7]     = old[3];
                w[3]     = 1'b0;
                w[12:11] = 2'b11;
            end
            OP_MRET: begin
                w[3]     = old[7];
                w[7]     = 1'b1;
                w[12:11] = 2'b11;
            end
            default: w = old;
        endcase
        return w;
    endfunction

    // Output image for a given state; evaluated on next-state values so every output is a flop.
    function automatic drive_t drive_f(input state_t st,
                                       input logic [2:0] op,
                                       input logic [`CSR_IDX-1:0] idx,
                                       input logic [`XLEN-1:0] src,
                                       input logic [`XLEN-1:0] pc,
                                       input logic [`XLEN-1:0] cause,
                                       input logic [`XLEN-1:0] old);
        drive_t d;
        d = '0;
        case (st)
            ST_IDLE: d.req_ready = 1'b1;
            ST_TRAP: begin
                d.csr_ena    = 1'b1;
                d.csr_write  = 1'b1;
                d.csr_idx    = ADDR_MEPC;
                d.csr_wdata  = {pc[`XLEN-1:1], 1'b0};
                d.csr_idx2   = ADDR_MCAUSE;
                d.csr_wdata2 = cause;
            end
            ST_RD: begin
                d.csr_ena  = 1'b1;
                d.csr_read = 1'b1;
                d.csr_idx  = idx;
                d.csr_idx2 = idx;
            end
            ST_WR: begin
                d.csr_ena    = 1'b1;
                d.csr_write  = 1'b1;
                d.csr_idx    = idx;
                d.csr_idx2   = idx;
                d.csr_wdata  = wr_data_f(op, old, src);
                d.csr_wdata2 = wr_data_f(op, old, src);
            end
            ST_RESP: begin
                d.resp_valid = 1'b1;
                d.resp_rdata = ((op == OP_TRAP) || (op == OP_MRET)) ? {`XLEN{1'b0}} : old;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t              state_r, state_nxt_s;
    logic [2:0]          op_r, op_nxt_s;
    logic [`CSR_IDX-1:0] idx_r, idx_nxt_s;
    logic [`XLEN-1:0]    src_r, src_nxt_s;
    logic                src_zero_r, src_zero_nxt_s;
    logic [`XLEN-1:0]    pc_r, pc_nxt_s;
    logic [`XLEN-1:0]    cause_r, cause_nxt_s;
    logic [`XLEN-1:0]    old_r, old_nxt_s;
    logic                no_write_s;
    drive_t              drive_r, drive_nxt_s;

    assign no_write_s = (((op_r == OP_CSRRS) || (op_r == OP_CSRRC)) && src_zero_r) || (op_r > OP_MRET);

    // Next-state and request/old-value capture logic.
    always_comb begin
        state_nxt_s    = state_r;
        op_nxt_s       = op_r;
        idx_nxt_s      = idx_r;
        src_nxt_s      = src_r;
        src_zero_nxt_s = src_zero_r;
        pc_nxt_s       = pc_r;
        cause_nxt_s    = cause_r;
        old_nxt_s      = old_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    op_nxt_s       = req_op;
                    // TRAP and MRET always target mstatus in their RD/WR phase
                    idx_nxt_s      = ((req_op == OP_TRAP) || (req_op == OP_MRET)) ? ADDR_MSTATUS : req_idx;
                    src_nxt_s      = req_src;
                    src_zero_nxt_s = req_src_zero;
                    pc_nxt_s       = req_pc;
                    cause_nxt_s    = req_cause;
                    if (req_op == OP_TRAP) begin
                        state_nxt_s = ST_TRAP;
                    end else if ((req_op == OP_MRET) && !STACK_EN) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TRAP: state_nxt_s = STACK_EN ? ST_RD : ST_RESP;
            ST_RD: begin
                old_nxt_s   = csr_rdata;
                state_nxt_s = no_write_s ? ST_RESP : ST_WR;
            end
            ST_WR:   state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = resp_ready ? ST_IDLE : ST_RESP;
            default: state_nxt_s = ST_IDLE;
        endcase
        drive_nxt_s = drive_f(state_nxt_s, op_nxt_s, idx_nxt_s, src_nxt_s, pc_nxt_s, cause_nxt_s, old_nxt_s);
    end

    // State, latched request and registered outputs with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            op_r       <= 3'd0;
            idx_r      <= {`CSR_IDX{1'b0}};
            src_r      <= {`XLEN{1'b0}};
            src_zero_r <= 1'b0;
            pc_r       <= {`XLEN{1'b0}};
            cause_r    <= {`XLEN{1'b0}};
            old_r      <= {`XLEN{1'b0}};
            drive_r    <= drive_f(ST_IDLE, 3'd0, {`CSR_IDX{1'b0}}, {`XLEN{1'b0}},
                                  {`XLEN{1'b0}}, {`XLEN{1'b0}}, {`XLEN{1'b0}});
        end else begin
            state_r    <= state_nxt_s;
            op_r       <= op_nxt_s;
            idx_r      <= idx_nxt_s;
            src_r      <= src_nxt_s;
            src_zero_r <= src_zero_nxt_s;
            pc_r       <= pc_nxt_s;
            cause_r    <= cause_nxt_s;
            old_r      <= old_nxt_s;
            drive_r    <= drive_nxt_s;
        end
    end

    assign req_ready  = drive_r.req_ready;
    assign resp_valid = drive_r.resp_valid;
    assign resp_rdata = drive_r.resp_rdata;
    assign csr_ena    = drive_r.csr_ena;
    assign csr_read   = drive_r.csr_read;
    assign csr_write  = drive_r.csr_write;
    assign csr_idx    = drive_r.csr_idx;
    assign csr_idx2   = drive_r.csr_idx2;
    assign csr_wdata  = drive_r.csr_wdata;
    assign csr_wdata2 = drive_r.csr_wdata2;

endmodule
